// File: rtl/alu_ctrl.sv
// Register-file controller sequencing an external combinational ALU.
// Commands are accepted in IDLE, executed in EXEC (ALU ops only) and written back in WB.
module alu_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREG  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [2:0]       cmd_rd,
  input  logic [2:0]       cmd_rs1,
  input  logic [2:0]       cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             busy,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LDI = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_rf [NREG];
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [3:0]       r_op;
  logic [2:0]       r_rd;
  logic [WIDTH-1:0] r_wb_val;
  logic             r_wb_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_flag;
  logic             r_zero_flag;
  logic             w_accept;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;

  // Register 0 and indices beyond the file depth read as zero.
  function automatic logic [WIDTH-1:0] rf_read(input logic [2:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    if (idx != 3'd0 && {29'd0, idx} < NREG) v = r_rf[idx];
    return v;
  endfunction

  assign w_accept  = cmd_valid && (r_state == IDLE);
  assign w_rs1_val = rf_read(cmd_rs1);
  assign w_rs2_val = rf_read(cmd_rs2);
  assign dbg_data  = rf_read(dbg_addr);

  assign result     = r_result;
  assign carry_flag = r_carry_flag;
  assign zero_flag  = r_zero_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rf         <= '{default: '0};
      r_opa        <= '0;
      r_opb        <= '0;
      r_op         <= '0;
      r_rd         <= '0;
      r_wb_val     <= '0;
      r_wb_carry   <= 1'b0;
      r_result     <= '0;
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      // r_wb_val holds the immediate for LDI and the captured ALU result otherwise.
      if (w_accept) begin
        r_opa      <= w_rs1_val;
        r_opb      <= w_rs2_val;
        r_op       <= cmd_op;
        r_rd       <= cmd_rd;
        r_wb_val   <= cmd_imm;
        r_wb_carry <= 1'b0;
      end
      if (r_state == EXEC) begin
        r_wb_val   <= alu_out;
        r_wb_carry <= (r_op == OP_ADD) && alu_carry;
      end
      if (r_state == WB) begin
        if (r_rd != 3'd0 && {29'd0, r_rd} < NREG) r_rf[r_rd] <= r_wb_val;
        r_result     <= r_wb_val;
        r_carry_flag <= r_wb_carry;
        r_zero_flag  <= (r_wb_val == '0);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = '0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = (cmd_op == OP_LDI) ? WB : EXEC;
      end
      EXEC: begin
        alu_a   = r_opa;
        alu_b   = r_opb;
        alu_sel = r_op;
        w_next  = WB;
      end
      WB: begin
        // Suppressed under reset so an aborted writeback never pulses.
        done   = !reset;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
